dq_word_write_seq: RTL
======================

Name: dq_word_write_seq

Overview:
- Sequencer that drives a bank of NWORDS 4-bit DQ latch words (D, en, Q per word) from a single valid/ready request port.
- Generates the data-setup / enable-strobe / data-hold pattern the latches need, then reads a word back.
- Sits directly upstream of the latch array: drives its D bus and per-word enables, and consumes its Q outputs.

Parameters:
- NWORDS, 8, number of 4-bit latch words driven (2..2**AW).
- AW, 3, address width.
- SETUP_CYC, 1, cycles arr_d is stable before enable rises (>=1).
- STROBE_CYC, 1, cycles the selected enable is high (>=1).
- HOLD_CYC, 1, cycles arr_d is held after enable falls (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  target word.
- req_wdata  in  4  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  4  word read back from the array.
- rsp_err  out  1  address >= NWORDS, valid with rsp_valid.
- arr_d  out  4  shared D bus to all words.
- arr_en  out  NWORDS  one-hot per-word enable.
- arr_q  in  4*NWORDS  word i on bits [4i+3:4i].

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, arr_d=0, arr_en=0. State is IDLE.
- States: IDLE, SETUP, STROBE, HOLD, READ, RESP.
- Accept: a request is taken when req_valid & req_ready at a rising edge. req_ready=1 only in IDLE. addr, we and wdata are latched at accept.
- Write path, IDLE->SETUP:
  - SETUP: arr_d=wdata, arr_en=0 for SETUP_CYC cycles.
  - STROBE: arr_en[addr]=1, arr_d=wdata for STROBE_CYC cycles.
  - HOLD: arr_en=0, arr_d=wdata for HOLD_CYC cycles.
  - RESP follows.
- Readback capture: on the HOLD->RESP edge, rsp_rdata <= arr_q[addr].
- Read path, IDLE->READ: READ lasts 1 cycle with arr_en=0 and arr_d=0. rsp_rdata <= arr_q[addr] on the READ->RESP edge.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency, counting cycle 1 as the cycle after the accept edge:
  - Write: rsp_valid in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1.
  - Read: rsp_valid in cycle 2.
  - Next accept is possible at the end of the cycle after RESP.
- arr_d=0 in IDLE, READ and RESP.
- arr_en is never more than one-hot and is nonzero only in STROBE.
- Out-of-range address (addr >= NWORDS):
  - The normal state sequence and timing still run, but arr_en stays 0.
  - In RESP: rsp_err=1, rsp_rdata=0.
- rsp_err is 0 in RESP for valid addresses and 0 outside RESP.
- Phase counter: a single down-counter sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC), reloaded on each phase entry. Any of the three parameters = 0 is an elaboration error.
- Reset mid-operation: rst_n=0 at any edge forces IDLE and all reset values at that edge. An in-flight request is dropped with no response, and arr_en is 0 from that edge on.
- Inputs during busy: req_valid while req_ready=0 is ignored. req_addr, req_we and req_wdata may change freely and have no effect.

Decomposition:
- Shared package dq_pkg:
  - DQ_W=4.
  - state enum seq_state_t {IDLE, SETUP, STROBE, HOLD, READ, RESP}.
  - Word-slice helper function for arr_q.
- One sub-module, dq_addr_dec:
  - Registered-free AW-to-NWORDS one-hot decoder with enable input.
  - Out-of-range output flag.
  - Used to form arr_en and rsp_err.

Test Plan:
- The bench models each word as a level-sensitive 4-bit latch on arr_d/arr_en.
- Reset: hold rst_n=0 for 2 cycles with req_valid=1 -> req_ready=1, arr_en=0, arr_d=0, rsp_valid=0, no accept.
- Write, defaults: addr=5, wdata=4'b1010 -> arr_d=1010 cycles 1-3, arr_en=8'b0010_0000 only in cycle 2, rsp_valid cycle 4, rsp_rdata=1010, rsp_err=0.
- Read after write: addr=5, then addr=2 -> rsp_valid cycle 2 with 1010, then with 0000. arr_en stays 0 throughout.
- Busy input: req_valid held high for 10 cycles with a changing address -> exactly one accept per IDLE cycle. Each arr_en pulse matches the address latched at its own accept.
- Out-of-range: NWORDS=6, write addr=7 -> arr_en stays 0, rsp_valid cycle 4 with rsp_err=1, rsp_rdata=0.
- Timing and mid-op reset: SETUP_CYC=2, STROBE_CYC=1, HOLD_CYC=3 -> enable in cycle 3, rsp_valid in cycle 7.
- Reset in STROBE -> arr_en=0 from the reset edge, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/dq_pkg.sv
// Shared types and helpers for the DQ latch-word write sequencer.
// Word width, FSM state encoding and the arr_q word-slice helper live here.
package dq_pkg;

   localparam int DQ_W        = 4;
   localparam int MAX_WORDS   = 64;
   localparam int SLICE_IDX_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      READ,
      RESP
   } seq_state_t;

   // Callers zero-extend their Q bus to MAX_WORDS words; the shifted index assumes DQ_W == 4.
   function automatic logic [DQ_W-1:0] word_slice(input logic [DQ_W*MAX_WORDS-1:0] q,
                                                  input logic [SLICE_IDX_W-1:0]    idx);
      return q[{idx, 2'b00} +: DQ_W];
   endfunction

endpackage

// File: rtl/dq_addr_dec.sv
// One-hot word-enable decoder with an out-of-range flag.
// Purely combinational; the sequencer registers its outputs.
module dq_addr_dec
   import dq_pkg::*;
#(
   parameter int NWORDS = 8,
   parameter int AW     = 3
) (
   input  logic              en,
   input  logic [AW-1:0]     addr,
   output logic [NWORDS-1:0] onehot,
   output logic              oor
);

   // An out-of-range address never selects a word, even with en high.
   always_comb begin
      oor    = (32'(addr) >= 32'(NWORDS));
      onehot = '0;
      for (int i = 0; i < NWORDS; i++) begin
         if (en && !oor && (32'(addr) == 32'(i))) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/dq_word_write_seq.sv
// Sequencer driving a bank of 4-bit DQ latch words from one valid/ready port:
// setup / strobe / hold write pattern, single-cycle read, then a one-cycle response.
module dq_word_write_seq
   import dq_pkg::*;
#(
   parameter int NWORDS     = 8,
   parameter int AW         = 3,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 1,
   parameter int HOLD_CYC   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [AW-1:0]          req_addr,
   input  logic [DQ_W-1:0]        req_wdata,
   output logic                   rsp_valid,
   output logic [DQ_W-1:0]        rsp_rdata,
   output logic                   rsp_err,
   output logic [DQ_W-1:0]        arr_d,
   output logic [NWORDS-1:0]      arr_en,
   input  logic [DQ_W*NWORDS-1:0] arr_q
);

   localparam int MAX_SH  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAX_CYC = (MAX_SH > HOLD_CYC) ? MAX_SH : HOLD_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
      $error("dq_word_write_seq: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
   end
   if (NWORDS < 2 || NWORDS > (2**AW) || AW > SLICE_IDX_W) begin : g_bad_size
      $error("dq_word_write_seq: NWORDS must be in 2..2**AW and AW at most SLICE_IDX_W");
   end

   seq_state_t              state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [AW-1:0]           addr_q, addr_nxt;
   logic [DQ_W-1:0]         wdata_q, wdata_nxt;
   logic                    accept;
   logic [NWORDS-1:0]       en_nxt;
   logic                    oor_nxt;
   logic [DQ_W-1:0]         d_nxt, rdata_nxt;
   logic [DQ_W*MAX_WORDS-1:0] q_ext;

   assign accept    = req_valid && req_ready;
   assign addr_nxt  = accept ? req_addr  : addr_q;
   assign wdata_nxt = accept ? req_wdata : wdata_q;

   always_comb begin
      q_ext = '0;
      q_ext[DQ_W*NWORDS-1:0] = arr_q;
   end

   // Next state; the phase counter reloads on every phase entry and counts down to zero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt != '0) ? cnt - CW'(1) : cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = req_we ? SETUP : READ;
               cnt_nxt   = CW'(SETUP_CYC - 1);
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nxt = STROBE;
               cnt_nxt   = CW'(STROBE_CYC - 1);
            end
         end
         STROBE: begin
            if (cnt == '0) begin
               state_nxt = HOLD;
               cnt_nxt   = CW'(HOLD_CYC - 1);
            end
         end
         HOLD:    if (cnt == '0) state_nxt = RESP;
         READ:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   dq_addr_dec #(
      .NWORDS (NWORDS),
      .AW     (AW)
   ) u_dec (
      .en     (state_nxt == STROBE),
      .addr   (addr_nxt),
      .onehot (en_nxt),
      .oor    (oor_nxt)
   );

   // Outputs are computed from the next state so every port comes straight off a flop.
   always_comb begin
      d_nxt     = '0;
      rdata_nxt = rsp_rdata;
      if (state_nxt inside {SETUP, STROBE, HOLD}) d_nxt = wdata_nxt;
      if (state_nxt == RESP) begin
         rdata_nxt = oor_nxt ? '0 : word_slice(q_ext, SLICE_IDX_W'(addr_nxt));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         arr_d     <= '0;
         arr_en    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         req_ready <= (state_nxt == IDLE);
         rsp_valid <= (state_nxt == RESP);
         rsp_rdata <= rdata_nxt;
         rsp_err   <= (state_nxt == RESP) && oor_nxt;
         arr_d     <= d_nxt;
         arr_en    <= en_nxt;
      end
   end

endmodule
